// File: rtl/intr_priority_ctrl.sv
// -----------------------------------------------------------------------------
// intr_priority_ctrl
//
// N-channel prioritised interrupt controller. It latches the maskable requests
// and a rising-edge NMI, applies the mask register and the global disable,
// picks one winner, and offers it to the multicycle controller with a req/ack
// handshake. The handler signals its return with eoi. The controller does not
// nest interrupts: while a handler runs, new requests wait in their pending
// state.
//
// Build option (macro INTC_IRQ_EDGE_EN):
//   defined   : a rising edge on irq[i] sets a sticky pending[i]. The bit is
//               cleared only when channel i is acked, so the source may pulse
//               irq[i] for a single cycle.
//   undefined : pending is irq registered every cycle (level mode). The source
//               must hold irq[i] until it is serviced. Ack clears nothing.
//
// Ports
//   clk         in   system clock; all state changes on the rising edge
//   rst         in   synchronous, active-high reset
//   irq         in   [N_IRQ]  maskable requests (channel 0 = highest priority)
//   nmi         in   non-maskable request, rising-edge sensitive
//   int_dis     in   global disable of the maskable channels (NMI unaffected)
//   mask_we     in   write strobe for the mask register
//   mask_wdata  in   [N_IRQ]  new mask value (1 = channel enabled)
//   int_ack     in   one-cycle pulse: controller took the offered request
//   eoi         in   one-cycle pulse: handler finished
//   int_req     out  request offered to the controller (registered)
//   is_nmi      out  offered/served request is the NMI
//   int_id      out  [$clog2(N_IRQ)] offered/served channel (0 for NMI)
//   vec_addr    out  [VEC_W] handler vector address
//   in_service  out  a handler is running
//   mask_q      out  [N_IRQ] current mask register
// -----------------------------------------------------------------------------
module intr_priority_ctrl #(
  parameter int                N_IRQ      = 8,
  parameter int                VEC_W      = 32,
  parameter logic [VEC_W-1:0]  VEC_BASE   = 32'h0000_0100,
  parameter int                VEC_STRIDE = 8,
  parameter logic [VEC_W-1:0]  NMI_VEC    = 32'h0000_0080,
  parameter logic [N_IRQ-1:0]  MASK_RST   = {N_IRQ{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IRQ-1:0]           irq,
  input  logic                       nmi,
  input  logic                       int_dis,
  input  logic                       mask_we,
  input  logic [N_IRQ-1:0]           mask_wdata,
  input  logic                       int_ack,
  input  logic                       eoi,
  output logic                       int_req,
  output logic                       is_nmi,
  output logic [$clog2(N_IRQ)-1:0]   int_id,
  output logic [VEC_W-1:0]           vec_addr,
  output logic                       in_service,
  output logic [N_IRQ-1:0]           mask_q
);

  localparam int ID_W = $clog2(N_IRQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic [N_IRQ-1:0]   pending_q,    pending_d;
  logic               nmi_prev_q;
  logic               nmi_pend_q,   nmi_pend_d;
  logic [N_IRQ-1:0]   mask_d;
  logic               int_req_q,    int_req_d;
  logic               is_nmi_q,     is_nmi_d;
  logic [ID_W-1:0]    int_id_q,     int_id_d;
  logic [VEC_W-1:0]   vec_addr_q,   vec_addr_d;
  logic               in_service_q, in_service_d;

  // ---------------------------------------------------------------------------
  // Arbitration results (combinational, from registered state)
  // ---------------------------------------------------------------------------
  logic [N_IRQ-1:0]   eligible;
  logic               offer_any;
  logic               win_nmi;
  logic [ID_W-1:0]    win_id;
  logic [VEC_W-1:0]   win_vec;

  // The controller acknowledges whatever is currently on the outputs, so the
  // registered id / is_nmi decide which pending source gets retired.
  logic               ack_take;
  assign ack_take = (state_q == REQ) && int_ack;

  // ---------------------------------------------------------------------------
  // Pending capture
  // ---------------------------------------------------------------------------
`ifdef INTC_IRQ_EDGE_EN
  logic [N_IRQ-1:0]   irq_prev_q;
  logic [N_IRQ-1:0]   ack_clr;

  // A fresh rising edge in the same cycle as the ack of that channel is a new
  // request and therefore wins over the clear.
  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_edge_pend
    assign ack_clr[gi]   = ack_take && !is_nmi_q && (int_id_q == ID_W'(gi));
    assign pending_d[gi] = (irq[gi] && !irq_prev_q[gi]) ||
                           (pending_q[gi] && !ack_clr[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
    end else begin
      irq_prev_q <= irq;
    end
  end
`else
  // Level mode: pending simply follows the sources one cycle late.
  assign pending_d = irq;
`endif

  // ---------------------------------------------------------------------------
  // Priority arbitration: NMI first, then the lowest eligible channel index.
  // ---------------------------------------------------------------------------
  always_comb begin
    eligible = pending_q & mask_q & {N_IRQ{~int_dis}};
    win_nmi  = nmi_pend_q;
    win_id   = '0;
    // Scan from the top so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = ID_W'(i);
      end
    end
    if (win_nmi) begin
      win_id = '0;
    end
    // Vector arithmetic is done in VEC_W bits and is allowed to wrap.
    win_vec   = win_nmi ? NMI_VEC
                        : VEC_BASE + VEC_W'(win_id) * VEC_W'(VEC_STRIDE);
    offer_any = nmi_pend_q || (|eligible);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    is_nmi_d     = is_nmi_q;
    int_id_d     = int_id_q;
    vec_addr_d   = vec_addr_q;
    in_service_d = in_service_q;

    // New mask is registered here, so arbitration sees it one cycle later.
    mask_d = mask_we ? mask_wdata : mask_q;

    // NMI pending is sticky; only the ack of an offered NMI retires it. A new
    // edge arriving in that same cycle is a separate request and re-arms it.
    nmi_pend_d = nmi_pend_q;
    if (ack_take && is_nmi_q) begin
      nmi_pend_d = 1'b0;
    end
    if (nmi && !nmi_prev_q) begin
      nmi_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (offer_any) begin
          state_d    = REQ;
          int_req_d  = 1'b1;
          is_nmi_d   = win_nmi;
          int_id_d   = win_id;
          vec_addr_d = win_vec;
        end
      end

      REQ: begin
        // Ack takes precedence over eoi and over any withdrawal in the same
        // cycle: the controller has already committed to the offered request.
        if (int_ack) begin
          state_d      = SERV;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end else if (!offer_any) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end else begin
          // Keep re-arbitrating so a late NMI or higher channel preempts.
          is_nmi_d   = win_nmi;
          int_id_d   = win_id;
          vec_addr_d = win_vec;
        end
      end

      SERV: begin
        if (eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end

      default: begin
        state_d      = IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      // Starting at 1 means an nmi already high through reset is not an edge.
      nmi_prev_q   <= 1'b1;
      nmi_pend_q   <= 1'b0;
      mask_q       <= MASK_RST;
      int_req_q    <= 1'b0;
      is_nmi_q     <= 1'b0;
      int_id_q     <= '0;
      vec_addr_q   <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      nmi_prev_q   <= nmi;
      nmi_pend_q   <= nmi_pend_d;
      mask_q       <= mask_d;
      int_req_q    <= int_req_d;
      is_nmi_q     <= is_nmi_d;
      int_id_q     <= int_id_d;
      vec_addr_q   <= vec_addr_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign is_nmi     = is_nmi_q;
  assign int_id     = int_id_q;
  assign vec_addr   = vec_addr_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_intr_priority_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for intr_priority_ctrl (N_IRQ = 8, default vectors).
// A directed table of per-cycle {inputs, expected outputs} rows walks the
// documented scenarios, then randomized stimulus is checked against a
// cycle-level reference model written from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_intr_priority_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        nmi;
  logic        int_dis;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        int_ack;
  logic        eoi;
  logic        int_req;
  logic        is_nmi;
  logic [2:0]  int_id;
  logic [31:0] vec_addr;
  logic        in_service;
  logic [7:0]  mask_q;

  intr_priority_ctrl #(
    .N_IRQ      (8),
    .VEC_W      (32),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (8),
    .NMI_VEC    (32'h0000_0080),
    .MASK_RST   (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .nmi        (nmi),
    .int_dis    (int_dis),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .is_nmi     (is_nmi),
    .int_id     (int_id),
    .vec_addr   (vec_addr),
    .in_service (in_service),
    .mask_q     (mask_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit [7:0]  irq;
    bit        nmi;
    bit        dis;
    bit        mwe;
    bit [7:0]  mwd;
    bit        ack;
    bit        eoi;
    bit        req;
    bit        isn;
    int        id;
    bit [31:0] vec;
    bit        serv;
    bit [7:0]  mask;
  } row_t;

  row_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model state (what the outputs should be after the next edge)
  // ---------------------------------------------------------------------------
  bit [7:0]  m_pend, m_mask, m_irq_prev;
  bit        m_nmi_pend, m_nmi_prev;
  bit        m_offer, m_serv, m_isnmi;
  int        m_id;
  bit [31:0] m_vec;

  task automatic add(input bit r, input bit [7:0] i, input bit n, input bit d,
                     input bit we, input bit [7:0] wd, input bit a, input bit e,
                     input bit xr, input bit xn, input int xi, input bit [31:0] xv,
                     input bit xs, input bit [7:0] xm);
    row_t t;
    t.rst = r; t.irq = i; t.nmi = n; t.dis = d; t.mwe = we; t.mwd = wd;
    t.ack = a; t.eoi = e; t.req = xr; t.isn = xn; t.id = xi; t.vec = xv;
    t.serv = xs; t.mask = xm;
    tbl.push_back(t);
  endtask

  task automatic chk(input string what, input int idx,
                     input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s #%0d: got %h expected %h", what, idx, got, exp);
    end
  endtask

  task automatic drive(input row_t t);
    rst = t.rst; irq = t.irq; nmi = t.nmi; int_dis = t.dis;
    mask_we = t.mwe; mask_wdata = t.mwd; int_ack = t.ack; eoi = t.eoi;
  endtask

  task automatic check_outputs(input string tag, input int idx, input row_t t);
    chk({tag, " int_req"},    idx, 64'(int_req),    64'(t.req));
    chk({tag, " is_nmi"},     idx, 64'(is_nmi),     64'(t.isn));
    chk({tag, " int_id"},     idx, 64'(int_id),     64'(t.id));
    chk({tag, " vec_addr"},   idx, 64'(vec_addr),   64'(t.vec));
    chk({tag, " in_service"}, idx, 64'(in_service), 64'(t.serv));
    chk({tag, " mask_q"},     idx, 64'(mask_q),     64'(t.mask));
    $display("%s %0d: irq=%h nmi=%0b ack=%0b eoi=%0b -> req=%0b nmi=%0b id=%0d vec=%h serv=%0b mask=%h",
             tag, idx, t.irq, t.nmi, t.ack, t.eoi, int_req, is_nmi, int_id,
             vec_addr, in_service, mask_q);
  endtask

  // Apply one cycle of inputs and advance the model by the rules:
  // pending/NMI capture, mask write, then offer / serve / withdraw.
  task automatic model_step(input row_t s);
    int        win;
    bit        any;
    bit        took;
    bit [7:0]  np;
    bit        nn;
    if (s.rst) begin
      m_pend = 0; m_mask = 8'hFF; m_irq_prev = 0; m_nmi_pend = 0; m_nmi_prev = 1;
      m_offer = 0; m_serv = 0; m_isnmi = 0; m_id = 0; m_vec = 0;
      return;
    end
    win = -1;
    for (int c = 0; c < 8; c++)
      if (win < 0 && m_pend[c] && m_mask[c] && !s.dis) win = c;
    any  = m_nmi_pend || (win >= 0);
    took = m_offer && s.ack;
`ifdef INTC_IRQ_EDGE_EN
    np = m_pend;
    if (took && !m_isnmi) np[m_id] = 1'b0;
    np = np | (s.irq & ~m_irq_prev);
`else
    np = s.irq;
`endif
    nn = (m_nmi_pend && !(took && m_isnmi)) || (s.nmi && !m_nmi_prev);
    if (took) begin
      m_offer = 0; m_serv = 1;
    end else if (m_serv) begin
      if (s.eoi) m_serv = 0;
    end else if (any) begin
      m_offer = 1;
      m_isnmi = m_nmi_pend;
      m_id    = m_isnmi ? 0 : win;
      m_vec   = m_isnmi ? 32'h80 : 32'h100 + 32'(m_id) * 8;
    end else begin
      m_offer = 0;
    end
    m_pend     = np;
    m_nmi_pend = nn;
    m_irq_prev = s.irq;
    m_nmi_prev = s.nmi;
    if (s.mwe) m_mask = s.mwd;
  endtask

  initial begin
    row_t s;
    row_t x;

    rst = 1'b1; irq = '0; nmi = 1'b1; int_dis = 1'b0; mask_we = 1'b0;
    mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;

    // ------------------------------------------------------------ directed --
`ifdef INTC_IRQ_EDGE_EN
    //  rst irq  nmi dis we wd   ack eoi | req isn id vec       serv mask
    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h10, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 1, 0,   0, 0, 4, 32'h120, 1, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 1,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 0, 0,   1, 0, 2, 32'h110, 0, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 1, 0,   0, 0, 2, 32'h110, 1, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 0, 1,   0, 0, 2, 32'h110, 0, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 0, 0,   1, 0, 5, 32'h128, 0, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 1, 0,   0, 0, 5, 32'h128, 1, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 0, 1,   0, 0, 5, 32'h128, 0, 8'hFF);
    add(0, 8'h24, 0, 0, 0, 8'h00, 0, 0,   0, 0, 5, 32'h128, 0, 8'hFF);
`else
    //  rst irq  nmi dis we wd   ack eoi | req isn id vec       serv mask
    add(1, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   1, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0,   0, 1, 0, 32'h080, 1, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1,   0, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h24, 1, 0, 0, 8'h00, 0, 0,   0, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h24, 1, 0, 0, 8'h00, 0, 0,   1, 0, 2, 32'h110, 0, 8'hFF);
    add(0, 8'h20, 1, 0, 0, 8'h00, 1, 0,   0, 0, 2, 32'h110, 1, 8'hFF);
    add(0, 8'h20, 1, 0, 0, 8'h00, 0, 1,   0, 0, 2, 32'h110, 0, 8'hFF);
    add(0, 8'h20, 1, 0, 0, 8'h00, 0, 0,   1, 0, 5, 32'h128, 0, 8'hFF);
    add(0, 8'h22, 1, 0, 0, 8'h00, 0, 0,   1, 0, 5, 32'h128, 0, 8'hFF);
    add(0, 8'h22, 1, 0, 0, 8'h00, 0, 0,   1, 0, 1, 32'h108, 0, 8'hFF);
    add(0, 8'h22, 1, 1, 0, 8'h00, 0, 0,   0, 0, 1, 32'h108, 0, 8'hFF);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0,   0, 0, 1, 32'h108, 0, 8'hFF);
    add(0, 8'h08, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1, 32'h108, 0, 8'hFF);
    add(0, 8'h08, 0, 0, 0, 8'h00, 0, 0,   1, 0, 3, 32'h118, 0, 8'hFF);
    add(0, 8'h08, 0, 0, 0, 8'h00, 1, 0,   0, 0, 3, 32'h118, 1, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 3, 32'h118, 1, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0,   0, 0, 3, 32'h118, 1, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1,   0, 0, 3, 32'h118, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   1, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0,   0, 1, 0, 32'h080, 1, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1,   0, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h01, 1, 0, 1, 8'hFE, 0, 0,   0, 1, 0, 32'h080, 0, 8'hFE);
    add(0, 8'h01, 1, 0, 0, 8'h00, 0, 0,   0, 1, 0, 32'h080, 0, 8'hFE);
    add(0, 8'h01, 1, 0, 0, 8'h00, 0, 0,   0, 1, 0, 32'h080, 0, 8'hFE);
    add(0, 8'h01, 1, 0, 1, 8'hFF, 0, 0,   0, 1, 0, 32'h080, 0, 8'hFF);
    add(0, 8'h01, 1, 0, 0, 8'h00, 0, 0,   1, 0, 0, 32'h100, 0, 8'hFF);
    add(0, 8'h01, 1, 0, 0, 8'h00, 1, 1,   0, 0, 0, 32'h100, 1, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1,   0, 0, 0, 32'h100, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 1, 0,   0, 0, 0, 32'h100, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 1, 0,   0, 0, 4, 32'h120, 1, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 1,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 1,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 0,   0, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 0, 0,   1, 0, 4, 32'h120, 0, 8'hFF);
    add(0, 8'h10, 1, 0, 0, 8'h00, 1, 0,   0, 0, 4, 32'h120, 1, 8'hFF);
    add(1, 8'h10, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0, 32'h000, 0, 8'hFF);
`endif

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r]);
      @(posedge clk);
      #1;
      check_outputs("row", r, tbl[r]);
    end

    // ---------------------------------------------------------- randomized --
    for (int c = 0; c < 600; c++) begin
      s.rst = (c == 0) || ($urandom_range(0, 199) == 0);
      s.irq = 8'($urandom) & 8'($urandom);
      s.nmi = ($urandom_range(0, 9) == 0) ? ~nmi : nmi;
      s.dis = ($urandom_range(0, 7) == 0);
      s.mwe = ($urandom_range(0, 15) == 0);
      s.mwd = 8'($urandom) | 8'($urandom);
      s.ack = m_offer ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      s.eoi = m_serv  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      drive(s);
      model_step(s);
      @(posedge clk);
      #1;
      x = s;
      x.req = m_offer; x.isn = m_isnmi; x.id = m_id; x.vec = m_vec;
      x.serv = m_serv; x.mask = m_mask;
      check_outputs("rnd", c, x);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
